// File: rtl/audio_write_scheduler_if.sv
// Bundles the two sample sources and the codec DAC write port of the audio write scheduler.
// The master modport is the scheduler's view; the slave modport is the sources-plus-codec side.
interface audio_write_scheduler_if #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
);
    logic              enable;
    logic              mus_valid;
    logic [DATA_W-1:0] mus_left;
    logic [DATA_W-1:0] mus_right;
    logic              mus_ready;
    logic              sfx_valid;
    logic [DATA_W-1:0] sfx_left;
    logic [DATA_W-1:0] sfx_right;
    logic              sfx_ready;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic              sfx_active;
    logic [CNT_W-1:0]  underrun_count;

    modport master (
        input  enable, mus_valid, mus_left, mus_right,
               sfx_valid, sfx_left, sfx_right, write_ready,
        output mus_ready, sfx_ready, write, writedata_left, writedata_right,
               sfx_active, underrun_count
    );

    modport slave (
        output enable, mus_valid, mus_left, mus_right,
               sfx_valid, sfx_left, sfx_right, write_ready,
        input  mus_ready, sfx_ready, write, writedata_left, writedata_right,
               sfx_active, underrun_count
    );
endinterface

// File: rtl/audio_write_scheduler.sv
// Pulls at most one stereo sample from the music and SFX sources per codec frame,
// mixes them with ducked saturating addition and issues a single-cycle DAC write.
module audio_write_scheduler #(
    parameter int DATA_W     = 24,
    parameter int DUCK_SHIFT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    audio_write_scheduler_if.master bus
);
    typedef enum logic [1:0] {S_WAIT, S_CAPTURE, S_MIX, S_WRITE} state_t;

    localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [DATA_W:0] SAT_MIN = -SAT_MAX - (DATA_W+1)'(1);

    state_t state;
    state_t next_state;

    logic                     mus_flag;
    logic                     sfx_flag;
    logic signed [DATA_W-1:0] mus_l;
    logic signed [DATA_W-1:0] mus_r;
    logic signed [DATA_W-1:0] sfx_l;
    logic signed [DATA_W-1:0] sfx_r;
    logic signed [DATA_W-1:0] mix_l;
    logic signed [DATA_W-1:0] mix_r;
    logic [DATA_W-1:0]        out_l;
    logic [DATA_W-1:0]        out_r;
    logic                     sfx_active_q;
    logic [CNT_W-1:0]         underrun_q;

    // One extra bit of headroom means the ducked sum can never wrap before the clamp.
    function automatic logic signed [DATA_W-1:0] mix_channel(
        input logic signed [DATA_W-1:0] m,
        input logic signed [DATA_W-1:0] s,
        input logic                     mf,
        input logic                     sf
    );
        logic signed [DATA_W:0] wide_m;
        logic signed [DATA_W:0] wide_s;
        logic signed [DATA_W:0] sum;
        wide_m = {m[DATA_W-1], m};
        wide_s = {s[DATA_W-1], s};
        sum    = (wide_m >>> DUCK_SHIFT) + wide_s;
        if (sum > SAT_MAX) begin
            sum = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            sum = SAT_MIN;
        end
        case ({mf, sf})
            2'b11:   mix_channel = sum[DATA_W-1:0];
            2'b10:   mix_channel = m;
            2'b01:   mix_channel = s;
            default: mix_channel = '0;
        endcase
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_WAIT:    if (bus.write_ready && bus.enable) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_MIX;
            S_MIX:     next_state = S_WRITE;
            S_WRITE:   next_state = S_WAIT;
            default:   next_state = S_WAIT;
        endcase
    end

    always_comb begin
        mix_l = mix_channel(mus_l, sfx_l, mus_flag, sfx_flag);
        mix_r = mix_channel(mus_r, sfx_r, mus_flag, sfx_flag);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mus_flag     <= 1'b0;
            sfx_flag     <= 1'b0;
            mus_l        <= '0;
            mus_r        <= '0;
            sfx_l        <= '0;
            sfx_r        <= '0;
            out_l        <= '0;
            out_r        <= '0;
            sfx_active_q <= 1'b0;
            underrun_q   <= '0;
        end else begin
            if (state == S_CAPTURE) begin
                mus_flag <= bus.mus_valid;
                sfx_flag <= bus.sfx_valid;
                if (bus.mus_valid) begin
                    mus_l <= bus.mus_left;
                    mus_r <= bus.mus_right;
                end
                if (bus.sfx_valid) begin
                    sfx_l <= bus.sfx_left;
                    sfx_r <= bus.sfx_right;
                end
            end
            if (state == S_MIX) begin
                out_l        <= mix_l;
                out_r        <= mix_r;
                sfx_active_q <= sfx_flag;
                if (!mus_flag && !sfx_flag && (underrun_q != '1)) begin
                    underrun_q <= underrun_q + CNT_W'(1);
                end
            end
        end
    end

    // Strobes are gated by reset so nothing escapes in the cycle that aborts a frame.
    assign bus.mus_ready       = (state == S_CAPTURE) && bus.mus_valid && !reset;
    assign bus.sfx_ready       = (state == S_CAPTURE) && bus.sfx_valid && !reset;
    assign bus.write           = (state == S_WRITE) && !reset;
    assign bus.writedata_left  = out_l;
    assign bus.writedata_right = out_r;
    assign bus.sfx_active      = sfx_active_q;
    assign bus.underrun_count  = underrun_q;
endmodule

// File: tb/tb_audio_write_scheduler.sv
// Directed bench for audio_write_scheduler: expected frames are queued when a frame is
// launched and popped by a write monitor; cycle-exact handshake checks run inline.
module tb_audio_write_scheduler;
    localparam int DATA_W = 24;
    // A narrow counter lets saturation be reached in a few dozen frames.
    localparam int CNT_W  = 5;

    typedef struct {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
        logic              sfx;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_write_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    audio_write_scheduler #(.DATA_W(DATA_W), .DUCK_SHIFT(1), .CNT_W(CNT_W)) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    frame_t sb[$];
    int checks          = 0;
    int failures        = 0;
    int write_count     = 0;
    int mus_ready_count = 0;
    int sfx_ready_count = 0;

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_mix(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] s,
                                                    input logic mv, input logic sv);
        int mi;
        int si;
        int r;
        mi = int'($signed(m));
        si = int'($signed(s));
        if (mv && sv)  r = (mi >>> 1) + si;
        else if (mv)   r = mi;
        else if (sv)   r = si;
        else           r = 0;
        if (r > 8388607)  r = 8388607;
        if (r < -8388608) r = -8388608;
        return r[DATA_W-1:0];
    endfunction

    always @(negedge clk) begin
        frame_t f;
        if (bus.write === 1'b1) begin
            write_count++;
            if (sb.size() == 0) begin
                check_bit("unexpected_write", bus.write, 1'b0);
            end else begin
                f = sb.pop_front();
                check_word("sb_left",  32'(bus.writedata_left),  32'(f.left));
                check_word("sb_right", 32'(bus.writedata_right), 32'(f.right));
                check_bit("sb_sfx_active", bus.sfx_active, f.sfx);
            end
        end
        if (bus.mus_ready === 1'b1) begin
            mus_ready_count++;
            check_bit("mus_ready_needs_valid", bus.mus_valid, 1'b1);
        end
        if (bus.sfx_ready === 1'b1) begin
            sfx_ready_count++;
            check_bit("sfx_ready_needs_valid", bus.sfx_valid, 1'b1);
        end
    end

    // Launches one frame with a single-cycle write_ready pulse and checks the
    // handshake cycle by cycle; the data itself is checked by the monitor.
    task automatic apply_stimulus(input string tag,
                                  input logic [DATA_W-1:0] ml, input logic [DATA_W-1:0] mr, input logic mv,
                                  input logic [DATA_W-1:0] sl, input logic [DATA_W-1:0] sr, input logic sv,
                                  input logic [DATA_W-1:0] el, input logic [DATA_W-1:0] er, input logic es);
        int mus0;
        int sfx0;
        int wr0;
        frame_t f;
        @(posedge clk); #1;
        bus.mus_valid   = mv;
        bus.mus_left    = ml;
        bus.mus_right   = mr;
        bus.sfx_valid   = sv;
        bus.sfx_left    = sl;
        bus.sfx_right   = sr;
        bus.enable      = 1'b1;
        bus.write_ready = 1'b1;
        f.left  = el;
        f.right = er;
        f.sfx   = es;
        sb.push_back(f);
        mus0 = mus_ready_count;
        sfx0 = sfx_ready_count;
        wr0  = write_count;
        @(posedge clk); #1;
        bus.write_ready = 1'b0;
        @(negedge clk);
        check_bit({tag, "_mus_ready"}, bus.mus_ready, mv);
        check_bit({tag, "_sfx_ready"}, bus.sfx_ready, sv);
        check_bit({tag, "_capture_write"}, bus.write, 1'b0);
        @(posedge clk); #1;
        bus.mus_valid = 1'b0;
        bus.sfx_valid = 1'b0;
        bus.mus_left  = DATA_W'($urandom);
        bus.sfx_left  = DATA_W'($urandom);
        @(negedge clk);
        check_bit({tag, "_mix_write"}, bus.write, 1'b0);
        @(negedge clk);
        check_bit({tag, "_write_strobe"}, bus.write, 1'b1);
        @(posedge clk); #1;
        check_word({tag, "_write_once"}, 32'(write_count - wr0), 32'd1);
        check_word({tag, "_mus_pulses"}, 32'(mus_ready_count - mus0), 32'(mv));
        check_word({tag, "_sfx_pulses"}, 32'(sfx_ready_count - sfx0), 32'(sv));
    endtask

    task automatic check_output(input string tag);
        check_bit({tag, "_write"}, bus.write, 1'b0);
        check_bit({tag, "_mus_ready"}, bus.mus_ready, 1'b0);
        check_bit({tag, "_sfx_ready"}, bus.sfx_ready, 1'b0);
        check_word({tag, "_left"}, 32'(bus.writedata_left), 32'd0);
        check_word({tag, "_right"}, 32'(bus.writedata_right), 32'd0);
        check_bit({tag, "_sfx_active"}, bus.sfx_active, 1'b0);
        check_word({tag, "_underrun"}, 32'(bus.underrun_count), 32'd0);
    endtask

    initial begin
        int wr0;
        int mus0;
        logic [DATA_W-1:0] ml, mr, sl, sr;
        logic mv, sv;

        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.write_ready = 1'b0;
        bus.mus_valid   = 1'b0;
        bus.mus_left    = '0;
        bus.mus_right   = '0;
        bus.sfx_valid   = 1'b0;
        bus.sfx_left    = '0;
        bus.sfx_right   = '0;
        repeat (3) @(negedge clk);
        check_output("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("after_reset");

        $display("[TB] music only");
        apply_stimulus("music_only", 24'h000100, 24'hFFFF00, 1'b1, 24'h0, 24'h0, 1'b0,
                       24'h000100, 24'hFFFF00, 1'b0);

        $display("[TB] ducked mix");
        apply_stimulus("ducked", 24'h200000, 24'h000010, 1'b1, 24'h100000, 24'h000002, 1'b1,
                       24'h200000, 24'h00000A, 1'b1);

        $display("[TB] saturation");
        apply_stimulus("saturate", 24'h7FFFFE, 24'h800000, 1'b1, 24'h7FFFFF, 24'h800000, 1'b1,
                       24'h7FFFFF, 24'h800000, 1'b1);

        $display("[TB] sfx only");
        apply_stimulus("sfx_only", 24'h0, 24'h0, 1'b0, 24'h123456, 24'hABCDEF, 1'b1,
                       24'h123456, 24'hABCDEF, 1'b1);
        check_word("no_underrun_yet", 32'(bus.underrun_count), 32'd0);

        $display("[TB] underrun");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("underrun", 24'h0, 24'h0, 1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0, 1'b0);
        end
        check_word("underrun_three", 32'(bus.underrun_count), 32'd3);
        for (int i = 0; i < (1 << CNT_W); i++) begin
            apply_stimulus("underrun_sat", 24'h0, 24'h0, 1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0, 1'b0);
        end
        check_word("underrun_saturated", 32'(bus.underrun_count), 32'((1 << CNT_W) - 1));

        $display("[TB] model-checked frames");
        for (int i = 0; i < 6; i++) begin
            ml = DATA_W'($urandom);
            mr = DATA_W'($urandom);
            sl = DATA_W'($urandom);
            sr = DATA_W'($urandom);
            mv = 1'b1;
            sv = (i % 3) != 2;
            apply_stimulus("random", ml, mr, mv, sl, sr, sv,
                           model_mix(ml, sl, mv, sv), model_mix(mr, sr, mv, sv), sv);
        end

        $display("[TB] enable gating");
        @(posedge clk); #1;
        bus.enable      = 1'b0;
        bus.write_ready = 1'b1;
        bus.mus_valid   = 1'b1;
        bus.mus_left    = 24'h000200;
        bus.mus_right   = 24'hFFFE00;
        wr0  = write_count;
        mus0 = mus_ready_count;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_bit("gated_write", bus.write, 1'b0);
        end
        check_word("gated_write_count", 32'(write_count - wr0), 32'd0);
        check_word("gated_ready_count", 32'(mus_ready_count - mus0), 32'd0);

        @(posedge clk); #1;
        bus.sfx_valid = 1'b1;
        bus.sfx_left  = 24'h000123;
        bus.sfx_right = 24'hFFFEDC;
        bus.enable    = 1'b1;
        sb.push_back('{left: 24'h000223, right: 24'hFFFDDC, sfx: 1'b1});
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        bus.mus_valid = 1'b0;
        bus.sfx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_word("enable_drop_writes", 32'(write_count - wr0), 32'd1);
        bus.write_ready = 1'b0;

        $display("[TB] reset mid-frame");
        wr0 = write_count;
        @(posedge clk); #1;
        bus.mus_valid   = 1'b1;
        bus.mus_left    = 24'h111111;
        bus.mus_right   = 24'h222222;
        bus.enable      = 1'b1;
        bus.write_ready = 1'b1;
        @(posedge clk); #1;
        bus.write_ready = 1'b0;
        @(posedge clk); #1;
        bus.mus_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        check_bit("reset_in_mix_write", bus.write, 1'b0);
        @(negedge clk);
        check_output("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("mid_reset_release");
        repeat (4) @(negedge clk);
        check_word("aborted_frame_writes", 32'(write_count - wr0), 32'd0);

        apply_stimulus("post_reset", 24'h000100, 24'hFFFF00, 1'b1, 24'h000040, 24'h000040, 1'b1,
                       24'h0000C0, 24'hFFFFC0, 1'b1);

        repeat (4) @(negedge clk);
        check_word("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
